fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO: DEPTH entries of {instruction, PC, prediction},
// first-word fall-through on the decode side, single-cycle flush on redirect.
module fetch_queue #(
   parameter int INSTR_W = 8,
   parameter int PC_W    = 16,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               f_valid,
   output logic               f_ready,
   input  logic [INSTR_W-1:0] f_instr,
   input  logic [PC_W-1:0]    f_pc,
   input  logic               f_pred_taken,
   input  logic [PC_W-1:0]    f_pred_target,
   output logic               d_valid,
   input  logic               d_ready,
   output logic [INSTR_W-1:0] d_instr,
   output logic [PC_W-1:0]    d_pc,
   output logic               d_pred_taken,
   output logic [PC_W-1:0]    d_pred_target,
   input  logic               flush,
   output logic [CNT_W-1:0]   count,
   output logic               empty,
   output logic               full
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               pred_taken;
      logic [PC_W-1:0]    pred_target;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             push;
   logic             pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign f_ready = !full && !rst;
   assign d_valid = !empty && !flush;

   // Flush beats any handshake in the same cycle; d_valid is already masked by flush.
   assign push = f_valid && f_ready && !flush;
   assign pop  = d_valid && d_ready;

   assign d_instr       = mem[head].instr;
   assign d_pc          = mem[head].pc;
   assign d_pred_taken  = mem[head].pred_taken;
   assign d_pred_target = mem[head].pred_target;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; its contents are only observed while
   // d_valid=1, and leaving it unreset lets it map onto plain register files.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= '{instr:       f_instr,
                        pc:          f_pc,
                        pred_taken:  f_pred_taken,
                        pred_target: f_pred_target};
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= CNT_W'(DEPTH));
   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(push && full));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
      !(pop && empty));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: reset, fill/drain, wrap streaming,
// full-with-pop, flush and asynchronous mid-operation reset.
module tb_fetch_queue;

   localparam int INSTR_W = 8;
   localparam int PC_W    = 16;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic               clk = 1'b0;
   logic               rst;
   logic               f_valid;
   logic               f_ready;
   logic [INSTR_W-1:0] f_instr;
   logic [PC_W-1:0]    f_pc;
   logic               f_pred_taken;
   logic [PC_W-1:0]    f_pred_target;
   logic               d_valid;
   logic               d_ready;
   logic [INSTR_W-1:0] d_instr;
   logic [PC_W-1:0]    d_pc;
   logic               d_pred_taken;
   logic [PC_W-1:0]    d_pred_target;
   logic               flush;
   logic [CNT_W-1:0]   count;
   logic               empty;
   logic               full;

   int n_checks = 0;
   int n_pass   = 0;

   fetch_queue #(.INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc),
      .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
      .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr), .d_pc(d_pc),
      .d_pred_taken(d_pred_taken), .d_pred_target(d_pred_target),
      .flush(flush), .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   // Fetch must hold its entry while it is being refused (it may withdraw it).
   a_fetch_stable: assert property (@(posedge clk) disable iff (rst)
      (f_valid && !f_ready) |=> (!f_valid ||
         $stable({f_instr, f_pc, f_pred_taken, f_pred_target})));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] instr, input logic [15:0] pc,
                        input logic taken, input logic [15:0] target);
      f_valid       = 1'b1;
      f_instr       = instr;
      f_pc          = pc;
      f_pred_taken  = taken;
      f_pred_target = target;
   endtask

   task automatic push_one(input logic [7:0] instr, input logic [15:0] pc);
      drive(instr, pc, instr[0], pc + 16'h0040);
      tick();
      f_valid = 1'b0;
   endtask

   // Pops one entry (d_ready for one edge) after checking the head fields.
   task automatic pop_check(input string tag, input logic [7:0] instr, input logic [15:0] pc);
      d_ready = 1'b1;
      #1;
      check({tag, "_dvalid"}, d_valid, 1'b1);
      check({tag, "_instr"}, d_instr, instr);
      check({tag, "_pc"}, d_pc, pc);
      check({tag, "_taken"}, d_pred_taken, instr[0]);
      check({tag, "_target"}, d_pred_target, pc + 16'h0040);
      tick();
      d_ready = 1'b0;
   endtask

   // Streaming-test entry generator.
   function automatic logic [7:0] s_instr(input int i);
      return 8'(8'h20 + i);
   endfunction
   function automatic logic [15:0] s_pc(input int i);
      return 16'(16'h0400 + i * 4);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      f_valid = 1'b0; f_instr = '0; f_pc = '0; f_pred_taken = 1'b0; f_pred_target = '0;
      d_ready = 1'b0; flush = 1'b0;

      // Reset and idle
      #1;
      check("rst_f_ready", f_ready, 1'b0);
      check("rst_d_valid", d_valid, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_count", count, 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("idle_count", count, 0);
      check("idle_empty", empty, 1'b1);
      check("idle_d_valid", d_valid, 1'b0);
      check("idle_f_ready", f_ready, 1'b1);

      // Fill with decode stalled, then drain in order
      for (int i = 0; i < 4; i++) push_one(8'(8'h11 + i), 16'(16'h0100 + i));
      check("fill_full", full, 1'b1);
      check("fill_f_ready", f_ready, 1'b0);
      check("fill_count", count, 4);
      drive(8'h15, 16'h0104, 1'b1, 16'h0144);
      tick();
      f_valid = 1'b0;
      check("refuse_count", count, 4);
      check("refuse_head", d_instr, 8'h11);
      for (int i = 0; i < 4; i++) pop_check("drain", 8'(8'h11 + i), 16'(16'h0100 + i));
      check("drain_empty", empty, 1'b1);
      check("drain_d_valid", d_valid, 1'b0);

      // Streaming across pointer wrap with decode ready toggling
      begin
         int sent = 0;
         int recv = 0;
         for (int cyc = 0; cyc < 100 && recv < 10; cyc++) begin
            if (sent < 10) drive(s_instr(sent), s_pc(sent), (sent % 3) == 0, s_pc(sent) + 16'h0040);
            else f_valid = 1'b0;
            d_ready = (cyc % 2) == 0;
            #1;
            check("wrap_count_bound", count <= 4, 1'b1);
            if (d_valid && d_ready) begin
               check("wrap_instr", d_instr, s_instr(recv));
               check("wrap_pc", d_pc, s_pc(recv));
               check("wrap_taken", d_pred_taken, (recv % 3) == 0);
               check("wrap_target", d_pred_target, s_pc(recv) + 16'h0040);
               recv++;
            end
            if (f_valid && f_ready) begin
               tick();
               sent++;
            end else tick();
         end
         f_valid = 1'b0;
         d_ready = 1'b0;
         check("wrap_received", recv, 10);
         check("wrap_empty", empty, 1'b1);
      end

      // Full with simultaneous pop: push refused, accepted next cycle
      for (int i = 0; i < 4; i++) push_one(8'(8'h31 + i), 16'(16'h0300 + i));
      drive(8'h35, 16'h0304, 1'b1, 16'h0344);
      d_ready = 1'b1;
      #1;
      check("fullpop_f_ready", f_ready, 1'b0);
      tick();
      d_ready = 1'b0;
      check("fullpop_count", count, 3);
      check("fullpop_head", d_instr, 8'h32);
      tick();
      f_valid = 1'b0;
      check("fullpop_refill", count, 4);
      for (int i = 1; i < 5; i++) pop_check("fullpop_drain", 8'(8'h31 + i), 16'(16'h0300 + i));
      check("fullpop_empty", empty, 1'b1);

      // Flush mid-stream drops everything including the same-cycle handshakes
      for (int i = 0; i < 3; i++) push_one(8'(8'h41 + i), 16'(16'h0500 + i));
      check("preflush_count", count, 3);
      drive(8'h44, 16'h0503, 1'b0, 16'h0543);
      d_ready = 1'b1;
      flush = 1'b1;
      #1;
      check("flush_d_valid", d_valid, 1'b0);
      check("flush_f_ready", f_ready, 1'b1);
      tick();
      flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
      #1;
      check("postflush_count", count, 0);
      check("postflush_empty", empty, 1'b1);
      check("postflush_d_valid", d_valid, 1'b0);
      push_one(8'hAA, 16'h0200);
      check("flush_follow_count", count, 1);
      pop_check("flush_follow", 8'hAA, 16'h0200);
      check("flush_follow_empty", empty, 1'b1);

      // Asynchronous reset between edges
      push_one(8'h51, 16'h0600);
      push_one(8'h52, 16'h0601);
      check("prerst_count", count, 2);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_d_valid", d_valid, 1'b0);
      check("arst_empty", empty, 1'b1);
      check("arst_f_ready", f_ready, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) push_one(8'(8'h61 + i), 16'(16'h0700 + i));
      check("arst_refill_count", count, 3);
      for (int i = 0; i < 3; i++) pop_check("arst_drain", 8'(8'h61 + i), 16'(16'h0700 + i));
      check("arst_final_empty", empty, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
